esc_pwm_bank: RTL

- Parametrised bank of NUM_CH ESC PWM generators. It replaces the fixed four-motor wrapper and its per-motor interface instances.
- Speed commands for all channels are captured on a write strobe and applied glitch-free at frame boundaries.
- Per-channel slew limiting, a post-reset arming interval and a fast motors_off cut are added.
- Sits between the flight controller speed outputs and the ESC pins.

---
 rtl/esc_pkg.sv | 37 +++
 rtl/esc_pwm_chan.sv | 56 +++++
 rtl/esc_pwm_bank.sv | 86 ++++++++
 3 files changed

// File: rtl/esc_pkg.sv
// Shared defaults and per-channel arithmetic helpers for the ESC PWM bank.
// Widths are carried as 32-bit unsigned so the helpers serve any parametrisation.
package esc_pkg;

  localparam int unsigned NUM_CH_DEF     = 4;
  localparam int unsigned SPD_W_DEF      = 11;
  localparam int unsigned PERIOD_DEF     = 125000;
  localparam int unsigned MIN_PULSE_DEF  = 50000;
  localparam int unsigned SCALE_DEF      = 24;
  localparam int unsigned SLEW_STEP_DEF  = 64;
  localparam int unsigned ARM_FRAMES_DEF = 400;

  // Pulse high time in clocks for an applied speed; motors_off forces speed 0.
  function automatic logic [31:0] calc_thr(input logic [31:0] act,
                                           input logic        motors_off,
                                           input logic [31:0] min_pulse,
                                           input logic [31:0] scale);
    logic [31:0] eff;
    eff = motors_off ? 32'd0 : act;
    return min_pulse + eff * scale;
  endfunction

  // Move act towards tgt by at most step.
  function automatic logic [31:0] slew_step(input logic [31:0] act,
                                            input logic [31:0] tgt,
                                            input logic [31:0] step);
    logic [31:0] nxt;
    nxt = act;
    if (tgt > act) begin
      nxt = ((tgt - act) > step) ? act + step : tgt;
    end else if (tgt < act) begin
      nxt = ((act - tgt) > step) ? act - step : tgt;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/esc_pwm_chan.sv
// One ESC channel: shadow target, slew-limited applied speed and registered PWM pin.
// The applied speed only moves on the frame boundary so each pulse is glitch-free.
module esc_pwm_chan
  import esc_pkg::*;
#(
  parameter int unsigned SPD_W     = SPD_W_DEF,
  parameter int unsigned MIN_PULSE = MIN_PULSE_DEF,
  parameter int unsigned SCALE     = SCALE_DEF,
  parameter int unsigned SLEW_STEP = SLEW_STEP_DEF,
  parameter int unsigned CNT_W     = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wrt,
  input  logic [SPD_W-1:0] spd,
  input  logic             bnd,
  input  logic             arm_en,
  input  logic             motors_off,
  input  logic [CNT_W-1:0] per_cnt,
  output logic             pwm
);

  logic [SPD_W-1:0] tgt_reg;
  logic [SPD_W-1:0] act_reg;
  logic [SPD_W-1:0] act_next;
  logic             pwm_reg;
  logic [31:0]      thr;

  always_comb begin
    thr      = calc_thr(32'(act_reg), motors_off, MIN_PULSE, SCALE);
    act_next = SPD_W'(slew_step(32'(act_reg), 32'(tgt_reg), SLEW_STEP));
    if (motors_off || !arm_en) begin
      act_next = '0;
    end
  end

  // A write on the boundary cycle lands in tgt_reg while act_reg still uses the old target.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_reg <= '0;
      act_reg <= '0;
      pwm_reg <= 1'b0;
    end else begin
      if (wrt) begin
        tgt_reg <= spd;
      end
      if (bnd) begin
        act_reg <= act_next;
      end
      pwm_reg <= (32'(per_cnt) < thr);
    end
  end

  assign pwm = pwm_reg;

endmodule

// File: rtl/esc_pwm_bank.sv
// Bank of NUM_CH ESC PWM generators sharing one frame counter and arming interval.
// Commands are captured on wrt and applied per channel at each frame boundary.
module esc_pwm_bank
  import esc_pkg::*;
#(
  parameter int unsigned NUM_CH     = NUM_CH_DEF,
  parameter int unsigned SPD_W      = SPD_W_DEF,
  parameter int unsigned PERIOD     = PERIOD_DEF,
  parameter int unsigned MIN_PULSE  = MIN_PULSE_DEF,
  parameter int unsigned SCALE      = SCALE_DEF,
  parameter int unsigned SLEW_STEP  = SLEW_STEP_DEF,
  parameter int unsigned ARM_FRAMES = ARM_FRAMES_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wrt,
  input  logic [NUM_CH*SPD_W-1:0] spd,
  input  logic                    motors_off,
  output logic [NUM_CH-1:0]       pwm,
  output logic                    armed,
  output logic                    frame_start
);

  localparam int unsigned CNT_W = $clog2(PERIOD);
  localparam int unsigned ARM_W = $clog2(ARM_FRAMES + 1);

  if (MIN_PULSE + ((1 << SPD_W) - 1) * SCALE >= PERIOD) begin : g_bad_cfg
    $error("esc_pwm_bank: MIN_PULSE + (2**SPD_W-1)*SCALE must be below PERIOD");
  end

  logic [CNT_W-1:0] per_cnt_reg;
  logic [ARM_W-1:0] arm_cnt_reg;
  logic             armed_reg;
  logic             frame_start_reg;
  logic             bnd;
  logic             arm_last;
  logic             arm_en;

  assign bnd      = (per_cnt_reg == CNT_W'(PERIOD - 1));
  assign arm_last = (arm_cnt_reg == ARM_W'(ARM_FRAMES - 1));
  // The boundary that sets armed already honours commands for the following frame.
  assign arm_en   = armed_reg | arm_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt_reg     <= '0;
      arm_cnt_reg     <= '0;
      armed_reg       <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      per_cnt_reg     <= bnd ? '0 : per_cnt_reg + 1'b1;
      frame_start_reg <= bnd;
      if (bnd && !armed_reg) begin
        arm_cnt_reg <= arm_cnt_reg + 1'b1;
        if (arm_last) begin
          armed_reg <= 1'b1;
        end
      end
    end
  end

  genvar gi;
  for (gi = 0; gi < NUM_CH; gi++) begin : g_chan
    esc_pwm_chan #(
      .SPD_W    (SPD_W),
      .MIN_PULSE(MIN_PULSE),
      .SCALE    (SCALE),
      .SLEW_STEP(SLEW_STEP),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .wrt       (wrt),
      .spd       (spd[gi*SPD_W +: SPD_W]),
      .bnd       (bnd),
      .arm_en    (arm_en),
      .motors_off(motors_off),
      .per_cnt   (per_cnt_reg),
      .pwm       (pwm[gi])
    );
  end

  assign armed       = armed_reg;
  assign frame_start = frame_start_reg;

endmodule
